// File: rtl/arp_frame_eth_tx.sv
// ARP frame transmitter: latches one ARP request/reply and emits the Ethernet
// header handshake plus the 28-byte ARP payload as an AXI-Stream.
module arp_frame_eth_tx #(
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  s_frame_valid,
  output logic                  s_frame_ready,
  input  logic [47:0]           s_eth_dest_mac,
  input  logic [47:0]           s_eth_src_mac,
  input  logic [15:0]           s_eth_type,
  input  logic [15:0]           s_arp_htype,
  input  logic [15:0]           s_arp_ptype,
  input  logic [15:0]           s_arp_oper,
  input  logic [47:0]           s_arp_sha,
  input  logic [31:0]           s_arp_spa,
  input  logic [47:0]           s_arp_tha,
  input  logic [31:0]           s_arp_tpa,

  output logic                  m_eth_hdr_valid,
  input  logic                  m_eth_hdr_ready,
  output logic [47:0]           m_eth_dest_mac,
  output logic [47:0]           m_eth_src_mac,
  output logic [15:0]           m_eth_type,

  output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_eth_payload_axis_tkeep,
  output logic                  m_eth_payload_axis_tvalid,
  input  logic                  m_eth_payload_axis_tready,
  output logic                  m_eth_payload_axis_tlast,
  output logic                  m_eth_payload_axis_tuser,

  output logic                  busy
);

  localparam int NBYTES = 28;
  localparam int NB     = (NBYTES + KEEP_WIDTH - 1) / KEEP_WIDTH;
  localparam int CW     = (NB > 1) ? $clog2(NB) : 1;
  localparam int PW     = NB * DATA_WIDTH;
  localparam int LASTK  = NBYTES - (NB - 1) * KEEP_WIDTH;

  localparam logic [KEEP_WIDTH-1:0] ALL_KEEP  = '1;
  localparam logic [KEEP_WIDTH-1:0] LAST_KEEP =
    (KEEP_ENABLE != 0) ? (ALL_KEEP >> (KEEP_WIDTH - LASTK)) : ALL_KEEP;
  localparam logic [CW-1:0] LASTB = CW'(NB - 1);

  logic [NBYTES*8-1:0]   msb_first;
  logic [PW-1:0]         pay_in;

  logic                  ready_q, ready_d;
  logic                  hdr_valid_q, hdr_valid_d;
  logic [47:0]           dest_q, dest_d;
  logic [47:0]           src_q, src_d;
  logic [15:0]           type_q, type_d;
  logic [PW-1:0]         pay_q, pay_d;
  logic [CW-1:0]         beat_q, beat_d;
  logic [CW-1:0]         nxt;
  logic                  tvalid_q, tvalid_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [KEEP_WIDTH-1:0] tkeep_q, tkeep_d;
  logic                  tlast_q, tlast_d;
  logic                  busy_q, busy_d;
  logic                  accept;
  logic                  beat_ok;

  // Wire-order byte stream, then byte-swap so byte 0 sits in the low lane.
  assign msb_first = {s_arp_htype, s_arp_ptype, 8'h06, 8'h04, s_arp_oper,
                      s_arp_sha, s_arp_spa, s_arp_tha, s_arp_tpa};

  always_comb begin
    pay_in = '0;
    for (int i = 0; i < NBYTES; i++) begin
      pay_in[8*i +: 8] = msb_first[8*(NBYTES-1-i) +: 8];
    end
  end

  assign accept  = s_frame_valid && ready_q;
  assign beat_ok = tvalid_q && m_eth_payload_axis_tready;
  assign nxt     = beat_q + 1'b1;

  always_comb begin
    hdr_valid_d = hdr_valid_q;
    dest_d      = dest_q;
    src_d       = src_q;
    type_d      = type_q;
    pay_d       = pay_q;
    beat_d      = beat_q;
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tlast_d     = tlast_q;
    busy_d      = busy_q;

    if (hdr_valid_q && m_eth_hdr_ready) begin
      hdr_valid_d = 1'b0;
    end

    if (beat_ok) begin
      if (tlast_q) begin
        tvalid_d = 1'b0;
        busy_d   = 1'b0;
        tlast_d  = 1'b0;
        tdata_d  = '0;
        tkeep_d  = '0;
        beat_d   = '0;
      end else begin
        beat_d  = nxt;
        tdata_d = pay_q[int'(nxt)*DATA_WIDTH +: DATA_WIDTH];
        tkeep_d = (nxt == LASTB) ? LAST_KEEP : ALL_KEEP;
        tlast_d = (nxt == LASTB);
      end
    end

    // Accept only happens when both channels are idle, so it never
    // collides with the header or beat updates above.
    if (accept) begin
      hdr_valid_d = 1'b1;
      dest_d      = s_eth_dest_mac;
      src_d       = s_eth_src_mac;
      type_d      = s_eth_type;
      pay_d       = pay_in;
      beat_d      = '0;
      tvalid_d    = 1'b1;
      busy_d      = 1'b1;
      tdata_d     = pay_in[DATA_WIDTH-1:0];
      tkeep_d     = (LASTB == '0) ? LAST_KEEP : ALL_KEEP;
      tlast_d     = (LASTB == '0);
    end

    ready_d = !hdr_valid_d && !tvalid_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q     <= 1'b0;
      hdr_valid_q <= 1'b0;
      dest_q      <= '0;
      src_q       <= '0;
      type_q      <= '0;
      pay_q       <= '0;
      beat_q      <= '0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tlast_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      ready_q     <= ready_d;
      hdr_valid_q <= hdr_valid_d;
      dest_q      <= dest_d;
      src_q       <= src_d;
      type_q      <= type_d;
      pay_q       <= pay_d;
      beat_q      <= beat_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tlast_q     <= tlast_d;
      busy_q      <= busy_d;
    end
  end

  assign s_frame_ready             = ready_q;
  assign m_eth_hdr_valid           = hdr_valid_q;
  assign m_eth_dest_mac            = dest_q;
  assign m_eth_src_mac             = src_q;
  assign m_eth_type                = type_q;
  assign m_eth_payload_axis_tdata  = tdata_q;
  assign m_eth_payload_axis_tkeep  = tkeep_q;
  assign m_eth_payload_axis_tvalid = tvalid_q;
  assign m_eth_payload_axis_tlast  = tlast_q;
  assign m_eth_payload_axis_tuser  = 1'b0;
  assign busy                      = busy_q;

endmodule

// File: tb/tb_arp_frame_eth_tx.sv
// Scoreboard bench for arp_frame_eth_tx at 64-bit payload width:
// a byte-list ARP model feeds expected headers/beats to a negedge monitor.
module tb_arp_frame_eth_tx;

  localparam int DW = 64;
  localparam int KW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_frame_valid = 1'b0;
  logic          s_frame_ready;
  logic [47:0]   s_eth_dest_mac = '0;
  logic [47:0]   s_eth_src_mac = '0;
  logic [15:0]   s_eth_type = '0;
  logic [15:0]   s_arp_htype = '0;
  logic [15:0]   s_arp_ptype = '0;
  logic [15:0]   s_arp_oper = '0;
  logic [47:0]   s_arp_sha = '0;
  logic [31:0]   s_arp_spa = '0;
  logic [47:0]   s_arp_tha = '0;
  logic [31:0]   s_arp_tpa = '0;
  logic          m_eth_hdr_valid;
  logic          m_eth_hdr_ready = 1'b1;
  logic [47:0]   m_eth_dest_mac;
  logic [47:0]   m_eth_src_mac;
  logic [15:0]   m_eth_type;
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic          tvalid;
  logic          tready = 1'b1;
  logic          tlast;
  logic          tuser;
  logic          busy;

  arp_frame_eth_tx #(.DATA_WIDTH(DW)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .s_frame_valid             (s_frame_valid),
    .s_frame_ready             (s_frame_ready),
    .s_eth_dest_mac            (s_eth_dest_mac),
    .s_eth_src_mac             (s_eth_src_mac),
    .s_eth_type                (s_eth_type),
    .s_arp_htype               (s_arp_htype),
    .s_arp_ptype               (s_arp_ptype),
    .s_arp_oper                (s_arp_oper),
    .s_arp_sha                 (s_arp_sha),
    .s_arp_spa                 (s_arp_spa),
    .s_arp_tha                 (s_arp_tha),
    .s_arp_tpa                 (s_arp_tpa),
    .m_eth_hdr_valid           (m_eth_hdr_valid),
    .m_eth_hdr_ready           (m_eth_hdr_ready),
    .m_eth_dest_mac            (m_eth_dest_mac),
    .m_eth_src_mac             (m_eth_src_mac),
    .m_eth_type                (m_eth_type),
    .m_eth_payload_axis_tdata  (tdata),
    .m_eth_payload_axis_tkeep  (tkeep),
    .m_eth_payload_axis_tvalid (tvalid),
    .m_eth_payload_axis_tready (tready),
    .m_eth_payload_axis_tlast  (tlast),
    .m_eth_payload_axis_tuser  (tuser),
    .busy                      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [47:0] dest;
    logic [47:0] src;
    logic [15:0] typ;
    logic [15:0] htype;
    logic [15:0] ptype;
    logic [15:0] oper;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [47:0] tha;
    logic [31:0] tpa;
  } frame_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  beat_t        beat_q[$];
  logic [111:0] hdr_q[$];

  int total = 0;
  int bad   = 0;
  int tr_mode = 0;
  int hr_rand = 0;
  int hdr_hold = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Reference: ARP byte list in wire order, chopped into KW-byte beats.
  task automatic expect_frame(input frame_t f);
    byte unsigned b[$];
    b.push_back(f.htype[15:8]); b.push_back(f.htype[7:0]);
    b.push_back(f.ptype[15:8]); b.push_back(f.ptype[7:0]);
    b.push_back(8'h06);         b.push_back(8'h04);
    b.push_back(f.oper[15:8]);  b.push_back(f.oper[7:0]);
    for (int i = 5; i >= 0; i--) b.push_back(f.sha[8*i +: 8]);
    for (int i = 3; i >= 0; i--) b.push_back(f.spa[8*i +: 8]);
    for (int i = 5; i >= 0; i--) b.push_back(f.tha[8*i +: 8]);
    for (int i = 3; i >= 0; i--) b.push_back(f.tpa[8*i +: 8]);
    hdr_q.push_back({f.dest, f.src, f.typ});
    for (int s = 0; s < b.size(); s += KW) begin
      beat_t bt;
      bt.data = '0;
      bt.keep = '0;
      for (int k = 0; k < KW; k++) begin
        if (s + k < b.size()) begin
          bt.data[8*k +: 8] = b[s+k];
          bt.keep[k] = 1'b1;
        end
      end
      bt.last = (s + KW >= b.size());
      beat_q.push_back(bt);
    end
  endtask

  function automatic frame_t rand_frame();
    frame_t f;
    f.dest  = 48'({$urandom(), $urandom()});
    f.src   = 48'({$urandom(), $urandom()});
    f.typ   = 16'h0806;
    f.htype = 16'($urandom());
    f.ptype = 16'($urandom());
    f.oper  = 16'($urandom_range(1, 2));
    f.sha   = 48'({$urandom(), $urandom()});
    f.spa   = $urandom();
    f.tha   = 48'({$urandom(), $urandom()});
    f.tpa   = $urandom();
    return f;
  endfunction

  task automatic drive_fields(input frame_t f);
    s_eth_dest_mac = f.dest;
    s_eth_src_mac  = f.src;
    s_eth_type     = f.typ;
    s_arp_htype    = f.htype;
    s_arp_ptype    = f.ptype;
    s_arp_oper     = f.oper;
    s_arp_sha      = f.sha;
    s_arp_spa      = f.spa;
    s_arp_tha      = f.tha;
    s_arp_tpa      = f.tpa;
  endtask

  task automatic send(input frame_t f);
    bit got = 0;
    @(posedge clk); #1;
    drive_fields(f);
    s_frame_valid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (s_frame_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      check("accept_timeout", 0, 1);
    end else begin
      check("accept_idle", 128'(beat_q.size() + hdr_q.size()), 0);
      expect_frame(f);
    end
    @(posedge clk); #1;
    s_frame_valid = 1'b0;
    drive_fields(rand_frame());
  endtask

  task automatic drain();
    bit done = 0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (beat_q.size() == 0 && hdr_q.size() == 0 && !busy) begin
        done = 1;
        break;
      end
    end
    check("drain", 128'(done), 1);
  endtask

  always @(posedge clk) begin
    #1;
    case (tr_mode)
      0:       tready = 1'b1;
      1:       tready = ~tready;
      default: tready = 1'($urandom_range(0, 1));
    endcase
    if (hdr_hold > 0) begin
      m_eth_hdr_ready = 1'b0;
      hdr_hold--;
    end else begin
      m_eth_hdr_ready = hr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  logic          stall_prev = 1'b0;
  logic [73:0]   stall_snap;
  logic [111:0]  eh;
  beat_t         eb;

  always @(negedge clk) begin
    if (!rst) begin
      stall_prev = 1'b0;
    end else begin
      if (m_eth_hdr_valid && m_eth_hdr_ready) begin
        if (hdr_q.size() == 0) begin
          check("hdr_unexpected", 1, 0);
        end else begin
          eh = hdr_q.pop_front();
          check("hdr", {m_eth_dest_mac, m_eth_src_mac, m_eth_type}, eh);
        end
      end
      if (stall_prev) begin
        check("stall_hold", {tvalid, tdata, tkeep, tlast}, stall_snap);
      end
      if (tvalid && tready) begin
        if (beat_q.size() == 0) begin
          check("beat_unexpected", 1, 0);
        end else begin
          eb = beat_q.pop_front();
          check("beat", {tdata, tkeep, tlast, tuser, busy},
                {eb.data, eb.keep, eb.last, 1'b0, 1'b1});
        end
      end
      stall_prev = tvalid && !tready;
      stall_snap = {tvalid, tdata, tkeep, tlast};
    end
  end

  initial begin
    frame_t f;
    bit     rose;

    #1;
    check("reset_out",
          {s_frame_ready, m_eth_hdr_valid, tvalid, tlast, tuser, busy,
           tdata, tkeep},
          0);
    #20;
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 128'(s_frame_ready), 1);

    // Directed broadcast request at full throughput.
    f.dest  = 48'hFFFF_FFFF_FFFF;
    f.src   = 48'h5A51_5253_5455;
    f.typ   = 16'h0806;
    f.htype = 16'h0001;
    f.ptype = 16'h0800;
    f.oper  = 16'h0001;
    f.sha   = 48'h5A51_5253_5455;
    f.spa   = 32'hC0A8_0164;
    f.tha   = 48'h0;
    f.tpa   = 32'hC0A8_0165;
    send(f);
    @(negedge clk);
    check("first_beat",
          {s_frame_ready, m_eth_hdr_valid, busy, tvalid, tdata},
          {1'b0, 1'b1, 1'b1, 1'b1, 64'h0100_0406_0008_0100});
    drain();

    // Payload stalled every other cycle.
    tr_mode = 1;
    send(f);
    drain();
    tr_mode = 0;

    // Header held off while payload completes.
    hdr_hold = 12;
    send(f);
    repeat (7) @(negedge clk);
    check("hdr_blocks_ready",
          {s_frame_ready, busy, m_eth_hdr_valid}, {1'b0, 1'b0, 1'b1});
    rose = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (s_frame_ready) begin
        rose = 1;
        break;
      end
    end
    check("ready_after_hdr", {rose, 1'(hdr_q.size() == 0)}, 2'b11);

    // Back-to-back: oper 1 then oper 2.
    send(f);
    f.oper = 16'h0002;
    send(f);
    drain();

    // Reset while the second beat is on the bus.
    send(f);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("reset_abort",
          {s_frame_ready, m_eth_hdr_valid, tvalid, busy, tlast}, 0);
    beat_q.delete();
    hdr_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    send(rand_frame());
    drain();

    // Randomized frames with random backpressure on both channels.
    tr_mode = 2;
    hr_rand = 1;
    for (int i = 0; i < 8; i++) begin
      send(rand_frame());
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arp_frame_eth_tx.md
Name: arp_frame_eth_tx

Overview:
- Serializes one ARP frame (Ethernet header fields plus ARP fields) into an Ethernet header handshake and a 28-byte AXI-Stream payload.
- Sits between the ARP cache/request logic and the Ethernet MAC-side multiplexer in the UDP/IP stack.
- One frame is accepted per transaction; the next is blocked until the current header and payload are fully sent.

Parameters:
- DATA_WIDTH, 8, payload tdata width in bits; must be a multiple of 8 (8/16/32/64 supported).
- KEEP_ENABLE, (DATA_WIDTH>8), 1 enables the tkeep output; 0 forces tkeep to all-ones.
- KEEP_WIDTH, (DATA_WIDTH/8), tkeep width in bytes.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- s_frame_valid  in  1  ARP frame fields valid
- s_frame_ready  out  1  frame accepted when valid&&ready
- s_eth_dest_mac  in  48  Ethernet destination MAC
- s_eth_src_mac  in  48  Ethernet source MAC
- s_eth_type  in  16  Ethernet type (0x0806 normally)
- s_arp_htype  in  16  ARP hardware type
- s_arp_ptype  in  16  ARP protocol type
- s_arp_oper  in  16  ARP operation
- s_arp_sha  in  48  sender hardware address
- s_arp_spa  in  32  sender protocol address
- s_arp_tha  in  48  target hardware address
- s_arp_tpa  in  32  target protocol address
- m_eth_hdr_valid  out  1  Ethernet header valid
- m_eth_hdr_ready  in  1  header consumed
- m_eth_dest_mac  out  48  latched dest MAC
- m_eth_src_mac  out  48  latched src MAC
- m_eth_type  out  16  latched eth type
- m_eth_payload_axis_tdata  out  DATA_WIDTH  payload data; byte 0 in bits [7:0]
- m_eth_payload_axis_tkeep  out  KEEP_WIDTH  byte enables
- m_eth_payload_axis_tvalid  out  1  payload beat valid
- m_eth_payload_axis_tready  in  1  payload beat accepted
- m_eth_payload_axis_tlast  out  1  final beat
- m_eth_payload_axis_tuser  out  1  error flag; always 0
- busy  out  1  payload transmission in progress

Behaviour:
- Reset (rst=0, asynchronous): s_frame_ready=0 while asserted, then 1 on the first clock after release. m_eth_hdr_valid=0, tvalid=0, tlast=0, tuser=0, busy=0, all data/keep outputs 0, beat counter 0.
- Idle: s_frame_ready=1 only when no header is pending and no payload is in progress.
- Accept (valid&&ready at edge):
  - Latch all inputs.
  - Next cycle: m_eth_hdr_valid=1 with latched eth fields, busy=1, s_frame_ready=0, and the first payload beat is presented (tvalid=1).
- Header: m_eth_hdr_valid and the header fields are held stable until m_eth_hdr_ready=1 at a clock edge, then valid drops. The header and payload channels are independent; either may complete first.
- Payload bytes, in order (28 total, multi-byte fields big-endian):
  - htype[15:8], htype[7:0]
  - ptype[15:8], ptype[7:0]
  - 0x06 (HLEN), 0x04 (PLEN)
  - oper[15:8], oper[7:0]
  - sha 6 bytes, MSB first
  - spa 4 bytes, MSB first
  - tha 6 bytes, MSB first
  - tpa 4 bytes, MSB first
- Beats = ceil(28/KEEP_WIDTH). Each beat carries the next KEEP_WIDTH bytes with byte k in bits [8k+7:8k].
- Last beat: tkeep marks only valid bytes, low bits contiguous (64-bit: 0x0F; 32-bit: 0xF; 16-bit: 0x3). Unused bytes are 0. All other beats have tkeep all-ones.
- Stall: a beat advances only on tvalid&&tready; data/keep/last are held stable while tready=0.
- tlast=1 only on the final beat.
- On final-beat acceptance: tvalid=0 and busy=0 next cycle. s_frame_ready returns to 1 once the header has also been consumed. A new frame may be accepted in that same cycle.
- Inputs changing while not accepting are ignored.
- Reset mid-frame aborts immediately; no partial resume.

Test Plan:
- Single frame, DATA_WIDTH=64, dest=FF:FF:FF:FF:FF:FF, src=5A:51:52:53:54:55, type=0x0806, htype=1, ptype=0x0800, oper=1, sha=5A5152535455, spa=192.168.1.100, tha=0, tpa=192.168.1.101, both readies=1.
  - Expected header: dest, src, type as given.
  - Expected payload, 4 beats, bytes 00 01 08 00 06 04 00 01 | 5A 51 52 53 54 55 C0 A8 | 01 64 00 00 00 00 00 00 | C0 A8 01 65; last tkeep=0x0F, tlast on beat 4, tuser=0.
- tready toggled 1/0 every cycle -> identical 4-beat payload, outputs stable during stalls, busy high until the last beat.
- m_eth_hdr_ready held 0 for 10 cycles -> payload completes, s_frame_ready stays 0 until the header is accepted, then rises.
- Back-to-back two frames with oper=1 then oper=2 -> second accepted only after the first completes; payload byte 7 = 0x01 then 0x02.
- Assert reset (rst=0) during beat 2 -> all valids/busy 0 immediately; after release, a fresh frame transmits fully and correctly.
